sync_fifo_ctrl: RTL and testbench

//  Pointer/flag controller for the single-clock FIFO memory (sync_fifo_mem).

---
 rtl/sync_fifo_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: pointer, occupancy and flag controller for a single-clock
// FIFO memory with first-word-fall-through reads. Depth need not be a power
// of two. Pointers wrap explicitly at MEM_DEPTH-1.

`ifndef CFG_FIFO_DEPTH
`define CFG_FIFO_DEPTH 8
`endif

module sync_fifo_ctrl #(
  parameter int MEM_DEPTH     = `CFG_FIFO_DEPTH,
  parameter int ADDR_WIDTH    = $clog2(MEM_DEPTH),
  parameter int CNT_WIDTH     = $clog2(MEM_DEPTH + 1),
  parameter int AFULL_THRESH  = MEM_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_FULL  = CNT_WIDTH'(MEM_DEPTH);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  AFULL_C   = CNT_WIDTH'(AFULL_THRESH);
  localparam logic [CNT_WIDTH-1:0]  AEMPTY_C  = CNT_WIDTH'(AEMPTY_THRESH);

  // Flag decode of an occupancy value: {full, empty, almost_full, almost_empty}.
  function automatic logic [3:0] decode_flags(input logic [CNT_WIDTH-1:0] cnt);
    logic [3:0] f;
    f[3] = (cnt == CNT_FULL);
    f[2] = (cnt == CNT_ZERO);
    f[1] = (cnt >= AFULL_C);
    f[0] = (cnt <= AEMPTY_C);
    return f;
  endfunction

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] ptr);
    logic [ADDR_WIDTH-1:0] n;
    if (ptr == LAST_ADDR) begin
      n = ADDR_ZERO;
    end else begin
      n = ptr + ADDR_ONE;
    end
    return n;
  endfunction

  localparam logic [3:0] FLAGS_RESET = decode_flags({CNT_WIDTH{1'b0}});

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q,  count_d;
  logic [3:0]            flags_q,  flags_d;
  logic                  overflow_q,  overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc_s, rd_acc_s;

  // Accept decisions use pre-edge flags: a full FIFO drops push even if pop frees a slot.
  always_comb begin
    wr_acc_s = push & ~flags_q[3];
    rd_acc_s = pop  & ~flags_q[2];
  end

  // Next-state for pointers, occupancy, flags and error pulses.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = push & flags_q[3];
    underflow_d = pop  & flags_q[2];

    if (wr_acc_s) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_acc_s) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    flags_d = decode_flags(count_d);
  end

  // State registers with synchronous active-low reset; memory contents are untouched.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q    <= ADDR_ZERO;
      rd_ptr_q    <= ADDR_ZERO;
      count_q     <= CNT_ZERO;
      flags_q     <= FLAGS_RESET;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      flags_q     <= flags_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Output mapping: write enable is combinational so the memory writes on the same edge.
  always_comb begin
    mem_wr_en    = wr_acc_s;
    mem_wr_addr  = wr_ptr_q;
    mem_rd_addr  = rd_ptr_q;
    count        = count_q;
    full         = flags_q[3];
    empty        = flags_q[2];
    almost_full  = flags_q[1];
    almost_empty = flags_q[0];
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

  sync_fifo_ctrl_chk #(
    .MEM_DEPTH  (MEM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_chk (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_addr   (wr_ptr_q),
    .rd_addr   (rd_ptr_q),
    .count     (count_q),
    .full      (flags_q[3]),
    .empty     (flags_q[2]),
    .overflow  (overflow_q),
    .underflow (underflow_q)
  );

endmodule

// sync_fifo_ctrl_chk: structural invariants of the controller state.
module sync_fifo_ctrl_chk #(
  parameter int MEM_DEPTH  = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int CNT_WIDTH  = 4
) (
  input logic                  clk,
  input logic                  reset_n,
  input logic [ADDR_WIDTH-1:0] wr_addr,
  input logic [ADDR_WIDTH-1:0] rd_addr,
  input logic [CNT_WIDTH-1:0]  count,
  input logic                  full,
  input logic                  empty,
  input logic                  overflow,
  input logic                  underflow
);

  int ptr_diff_s;

  // Modular pointer distance, the occupancy expected whenever not full.
  always_comb begin
    if (int'(wr_addr) >= int'(rd_addr)) begin
      ptr_diff_s = int'(wr_addr) - int'(rd_addr);
    end else begin
      ptr_diff_s = int'(wr_addr) + MEM_DEPTH - int'(rd_addr);
    end
  end

  a_count_range: assert property (@(posedge clk) disable iff (!reset_n)
    int'(count) <= MEM_DEPTH);
  a_ptr_invariant: assert property (@(posedge clk) disable iff (!reset_n)
    (!full) |-> (int'(count) == ptr_diff_s));
  a_full_ptrs: assert property (@(posedge clk) disable iff (!reset_n)
    full |-> (wr_addr == rd_addr));
  a_flags_excl: assert property (@(posedge clk) disable iff (!reset_n)
    !(full && empty));
  a_err_excl: assert property (@(posedge clk) disable iff (!reset_n)
    !(overflow && underflow));

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Testbench for sync_fifo_ctrl: directed scenarios then random push/pop,
// checked against a queue-based reference model and a bench-side memory.

module tb_sync_fifo_ctrl;

  localparam int DEPTH = 6;
  localparam int AW    = 3;
  localparam int CW    = 3;
  localparam int AFT   = 4;
  localparam int AET   = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          push;
  logic          pop;
  logic [7:0]    wdata;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [AW-1:0] mem_rd_addr;
  logic          full, empty, almost_full, almost_empty;
  logic [CW-1:0] count;
  logic          overflow, underflow;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .MEM_DEPTH     (DEPTH),
    .AFULL_THRESH  (AFT),
    .AEMPTY_THRESH (AET)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .push         (push),
    .pop          (pop),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_rd_addr  (mem_rd_addr),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Bench-side stand-in for the FIFO memory.
  logic [7:0] tb_mem [DEPTH];
  always @(posedge clk) begin
    if (mem_wr_en === 1'b1) tb_mem[mem_wr_addr] <= wdata;
  end

  // Reference model: contents as a queue, pointers as plain modular integers.
  logic [7:0] q[$];
  int  m_wr = 0;
  int  m_rd = 0;
  bit  m_ovf = 1'b0;
  bit  m_udf = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string ctx);
    int n;
    n = q.size();
    chk({ctx, "/count"},        32'(count),        32'(n));
    chk({ctx, "/empty"},        32'(empty),        32'(n == 0));
    chk({ctx, "/full"},         32'(full),         32'(n == DEPTH));
    chk({ctx, "/almost_full"},  32'(almost_full),  32'(n >= AFT));
    chk({ctx, "/almost_empty"}, 32'(almost_empty), 32'(n <= AET));
    chk({ctx, "/overflow"},     32'(overflow),     32'(m_ovf));
    chk({ctx, "/underflow"},    32'(underflow),    32'(m_udf));
    chk({ctx, "/wr_addr"},      32'(mem_wr_addr),  32'(m_wr));
    chk({ctx, "/rd_addr"},      32'(mem_rd_addr),  32'(m_rd));
  endtask

  task automatic step(input string ctx, input bit p, input bit r, input logic [7:0] d);
    bit wa, ra;
    @(negedge clk);
    push = p; pop = r; wdata = d;
    #1;
    wa = p && (q.size() < DEPTH);
    ra = r && (q.size() > 0);
    chk({ctx, "/mem_wr_en"}, 32'(mem_wr_en), 32'(wa));
    if (q.size() > 0) chk({ctx, "/rd_data"}, 32'(tb_mem[mem_rd_addr]), 32'(q[0]));
    m_ovf = p && !wa;
    m_udf = r && !ra;
    if (ra) begin
      void'(q.pop_front());
      m_rd = (m_rd + 1) % DEPTH;
    end
    if (wa) begin
      q.push_back(d);
      m_wr = (m_wr + 1) % DEPTH;
    end
    @(posedge clk);
    #1;
    check_state(ctx);
  endtask

  task automatic do_reset(input string ctx);
    @(negedge clk);
    reset_n = 1'b0; push = 1'b0; pop = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    m_wr = 0; m_rd = 0; m_ovf = 1'b0; m_udf = 1'b0;
    check_state(ctx);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    bit p, r;
    int bias;
    reset_n = 1'b0; push = 1'b0; pop = 1'b0; wdata = 8'h00;
    repeat (2) @(posedge clk);
    do_reset("reset");

    // Fill with 0xA0..0xA5.
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, 8'(8'hA0 + i));
    // Push into a full FIFO, then an idle cycle to see the pulse drop.
    step("ovf", 1'b1, 1'b0, 8'h5A);
    step("ovf_idle", 1'b0, 1'b0, 8'h00);
    // Drain; rd_data checked against 0xA0..0xA5 in order.
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b1, 8'h00);
    // Empty with simultaneous push and pop.
    step("udf", 1'b1, 1'b1, 8'hC3);
    step("udf_idle", 1'b0, 1'b0, 8'h00);
    // Bring count to 3, then steady push+pop across pointer wraps.
    step("to3", 1'b1, 1'b0, 8'hC4);
    step("to3", 1'b1, 1'b0, 8'hC5);
    for (int i = 0; i < 10; i++) step("steady", 1'b1, 1'b1, 8'(8'h10 + i));
    step("to4", 1'b1, 1'b0, 8'hD0);
    do_reset("mid_reset");
    step("post_reset", 1'b0, 1'b0, 8'h00);

    // Random traffic with alternating bias to visit full and empty often.
    for (int i = 0; i < 400; i++) begin
      bias = ((i / 40) % 2 == 0) ? 75 : 25;
      p = ($urandom_range(0, 99) < bias);
      r = ($urandom_range(0, 99) < (100 - bias));
      step("rand", p, r, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
